// File: rtl/ldl_p2ram_reader.sv
// ldl_p2ram_reader: read-side burst controller for the pseudo-dual-port RAM.
// Accepts (address, length) bursts, drives the RAM read port, absorbs the
// one-cycle registered read latency and streams words out through a
// two-entry skid buffer with a last-word marker.
// Optional feature: define LDL_P2RAM_READER_CNT_EN to add the 16-bit
// burst_cnt output counting completed bursts.
module ldl_p2ram_reader #(
  parameter int DWIDTH = 8,
  parameter int DEEPTH = 10,
  parameter int AWIDTH = $clog2(DEEPTH),
  parameter int LWIDTH = AWIDTH + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [AWIDTH-1:0] req_addr,
  input  logic [LWIDTH-1:0] req_len,
  output logic              ram_re,
  output logic [AWIDTH-1:0] ram_ra,
  input  logic [DWIDTH-1:0] ram_dout,
  output logic              o_valid,
  input  logic              o_ready,
  output logic [DWIDTH-1:0] o_data,
  output logic              o_last,
  output logic              busy
`ifdef LDL_P2RAM_READER_CNT_EN
  ,
  output logic [15:0]       burst_cnt
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_t;

  state_t            state;
  logic [LWIDTH-1:0] remain;
  logic [AWIDTH-1:0] ra_q;
  logic              inflight;
  logic              inflight_last;
  logic [1:0]        entries;
  logic [DWIDTH-1:0] head_data;
  logic [DWIDTH-1:0] tail_data;
  logic              head_last;
  logic              tail_last;
  logic              pop;
  logic              issue;
  logic              credit;
  logic              zero_len;
  logic              last_read;
  logic [2:0]        occ;
  logic [AWIDTH-1:0] start_addr;

  function automatic logic [AWIDTH-1:0] wrap_inc(input logic [AWIDTH-1:0] a);
    if (a == AWIDTH'(DEEPTH - 1)) return '0;
    return a + AWIDTH'(1);
  endfunction

  assign req_ready  = (state == IDLE);
  assign zero_len   = (req_len == '0);
  assign start_addr = ({1'b0, req_addr} >= (AWIDTH + 1)'(DEEPTH)) ? '0 : req_addr;
  assign o_valid    = (entries != 2'd0);
  assign o_data     = head_data;
  assign o_last     = head_last;
  assign pop        = o_valid && o_ready;
  assign occ        = 3'(entries) + 3'(inflight) - 3'(pop);
  assign credit     = (occ < 3'd2);
  // ram_re is decoded from registered state plus the current pop so a read can
  // be issued in the same cycle a buffered word leaves; a fully registered
  // enable would see a three-cycle credit loop and bubble with two entries.
  assign issue      = (state == RUN) && credit;
  assign last_read  = (remain == LWIDTH'(1));
  assign ram_re     = issue;
  assign ram_ra     = ra_q;

  // Burst control FSM: request acceptance, read issue and completion.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      remain <= '0;
      ra_q   <= '0;
      busy   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          busy <= 1'b0;
          if (req_valid) begin
            busy <= 1'b1;
            if (!zero_len) begin
              state  <= RUN;
              remain <= req_len;
              ra_q   <= start_addr;
            end
          end
        end
        RUN: begin
          if (issue) begin
            remain <= remain - LWIDTH'(1);
            // Address stays on the final read so ram_ra holds while idle.
            if (last_read) state <= DRAIN;
            else           ra_q  <= wrap_inc(ra_q);
          end
        end
        DRAIN: begin
          if (pop && head_last) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Track the read in flight so its data is captured one cycle later.
  always_ff @(posedge clk) begin
    if (rst) begin
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
    end else begin
      inflight      <= issue;
      inflight_last <= issue && last_read;
    end
  end

  // Two-entry output buffer; head drives the output and only moves on a pop
  // or when a word lands in an empty buffer, keeping outputs stable on stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      entries   <= 2'd0;
      head_data <= '0;
      head_last <= 1'b0;
      tail_data <= '0;
      tail_last <= 1'b0;
    end else begin
      case ({inflight, pop})
        2'b10: begin
          if (entries == 2'd0) begin
            head_data <= ram_dout;
            head_last <= inflight_last;
          end else begin
            tail_data <= ram_dout;
            tail_last <= inflight_last;
          end
          entries <= entries + 2'd1;
        end
        2'b01: begin
          head_data <= tail_data;
          head_last <= tail_last;
          entries   <= entries - 2'd1;
        end
        2'b11: begin
          if (entries == 2'd1) begin
            head_data <= ram_dout;
            head_last <= inflight_last;
          end else begin
            head_data <= tail_data;
            head_last <= tail_last;
            tail_data <= ram_dout;
            tail_last <= inflight_last;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef LDL_P2RAM_READER_CNT_EN
  // Completed-burst counter: final-word handshakes and zero-length requests.
  always_ff @(posedge clk) begin
    if (rst) begin
      burst_cnt <= '0;
    end else if ((pop && head_last) || (req_valid && req_ready && zero_len)) begin
      burst_cnt <= burst_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ldl_p2ram_reader.sv
// Scoreboard bench for ldl_p2ram_reader: stimulus pushes expected read
// addresses and output words into queues; a negedge monitor pops and compares.
module tb_ldl_p2ram_reader;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [3:0] req_addr = '0;
  logic [4:0] req_len = '0;
  logic       ram_re;
  logic [3:0] ram_ra;
  logic [7:0] ram_dout = '0;
  logic       o_valid;
  logic       o_ready = 1'b1;
  logic [7:0] o_data;
  logic       o_last;
  logic       busy;
`ifdef LDL_P2RAM_READER_CNT_EN
  logic [15:0] burst_cnt;
`endif

  int checks = 0;
  int errors = 0;
  int issued = 0;
  int popped = 0;
  int hs_count = 0;
  int max_out = 0;
  int exp_bursts = 0;
  bit flushing = 1'b0;

  logic [3:0] aq[$];
  logic [8:0] dq[$];
  logic [7:0] mem[16];

  always #5 clk = ~clk;

  ldl_p2ram_reader #(.DWIDTH(8), .DEEPTH(10)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_len(req_len), .ram_re(ram_re), .ram_ra(ram_ra),
    .ram_dout(ram_dout), .o_valid(o_valid), .o_ready(o_ready), .o_data(o_data),
    .o_last(o_last), .busy(busy)
`ifdef LDL_P2RAM_READER_CNT_EN
    , .burst_cnt(burst_cnt)
`endif
  );

  // RAM model: registered read, contents mem[i] = 16*i + 5.
  initial for (int i = 0; i < 16; i++) mem[i] = 8'(i * 16 + 5);
  always @(posedge clk) if (ram_re) ram_dout <= mem[ram_ra];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: compares every issued read and every output handshake.
  always @(negedge clk) begin
    if (!rst && !flushing) begin
      if (ram_re) begin
        issued++;
        checks++;
        if (aq.size() == 0) begin
          errors++;
          $display("FAIL ram_re_unexpected: got ra=%0d expected no read", ram_ra);
        end else begin
          logic [3:0] ea;
          ea = aq.pop_front();
          if (ram_ra !== ea) begin
            errors++;
            $display("FAIL ram_ra: got %0d expected %0d", ram_ra, ea);
          end
        end
      end
      if (o_valid && o_ready) begin
        popped++;
        hs_count++;
        checks++;
        if (dq.size() == 0) begin
          errors++;
          $display("FAIL o_valid_unexpected: got data=%0h last=%0b expected none", o_data, o_last);
        end else begin
          logic [8:0] ew;
          ew = dq.pop_front();
          if ({o_last, o_data} !== ew) begin
            errors++;
            $display("FAIL o_word: got last=%0b data=%0h expected last=%0b data=%0h",
                     o_last, o_data, ew[8], ew[7:0]);
          end
        end
      end
      if (issued - popped > max_out) max_out = issued - popped;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Expected read addresses and words for a burst.
  task automatic expect_burst(input int a, input int l);
    int a0;
    a0 = (a >= 10) ? 0 : a;
    for (int i = 0; i < l; i++) begin
      int ad;
      ad = (a0 + i) % 10;
      aq.push_back(4'(ad));
      dq.push_back({(i == l - 1), 8'(ad * 16 + 5)});
    end
  endtask

  task automatic send(input int a, input int l);
    expect_burst(a, l);
    req_addr  = 4'(a);
    req_len   = 5'(l);
    req_valid = 1'b1;
    chk("req_ready_at_send", {31'b0, req_ready}, 1);
    tick;
    req_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while ((busy || aq.size() != 0 || dq.size() != 0) && n < budget) begin
      tick;
      n++;
    end
    checks++;
    if (n >= budget) begin
      errors++;
      $display("FAIL wait_idle_timeout: got busy=%0b pending=%0d expected idle", busy, dq.size());
    end
    chk("aq_empty", aq.size(), 0);
    chk("dq_empty", dq.size(), 0);
  endtask

  task automatic check_cnt;
`ifdef LDL_P2RAM_READER_CNT_EN
    chk("burst_cnt", {16'b0, burst_cnt}, exp_bursts);
`endif
  endtask

  // addr 2, len 4, o_ready high: cycle-exact latency, throughput and busy.
  task automatic run_basic;
    logic [0:6] p_re, p_val, p_busy, p_rdy;
    p_re = 7'b1111000; p_val = 7'b0011110; p_busy = 7'b1111110; p_rdy = 7'b0000001;
    o_ready = 1'b1;
    send(2, 4);
    for (int k = 0; k < 7; k++) begin
      chk($sformatf("ram_re_t%0d", k + 1), {31'b0, ram_re}, {31'b0, p_re[k]});
      chk($sformatf("o_valid_t%0d", k + 1), {31'b0, o_valid}, {31'b0, p_val[k]});
      chk($sformatf("busy_t%0d", k + 1), {31'b0, busy}, {31'b0, p_busy[k]});
      chk($sformatf("req_ready_t%0d", k + 1), {31'b0, req_ready}, {31'b0, p_rdy[k]});
      if (k == 2) chk("first_word", {24'b0, o_data}, 32'h25);
      if (k == 5) chk("last_word", {23'b0, o_last, o_data}, 32'h155);
      tick;
    end
    exp_bursts++;
    wait_idle(50);
    check_cnt();
  endtask

  initial begin
    logic [0:15] rp;
    rp = 16'b1001010001101011;
    // Reset state.
    repeat (3) tick;
    rst = 1'b0;
    chk("rst_req_ready", {31'b0, req_ready}, 1);
    chk("rst_ram_re", {31'b0, ram_re}, 0);
    chk("rst_ram_ra", {28'b0, ram_ra}, 0);
    chk("rst_o_valid", {31'b0, o_valid}, 0);
    chk("rst_o_data", {24'b0, o_data}, 0);
    chk("rst_o_last", {31'b0, o_last}, 0);
    chk("rst_busy", {31'b0, busy}, 0);
    check_cnt();

    // Zero-length request: one-cycle busy pulse, no reads, no output.
    send(5, 0);
    chk("zl_busy_hi", {31'b0, busy}, 1);
    chk("zl_req_ready", {31'b0, req_ready}, 1);
    chk("zl_ram_re", {31'b0, ram_re}, 0);
    chk("zl_o_valid", {31'b0, o_valid}, 0);
    tick;
    chk("zl_busy_lo", {31'b0, busy}, 0);
    exp_bursts++;
    check_cnt();
    repeat (4) tick;

    run_basic();

    // Wrap-around 8,9,0,1 and an out-of-range start address mapped to 0.
    send(8, 4);
    exp_bursts++;
    wait_idle(50);
    send(12, 2);
    exp_bursts++;
    wait_idle(50);
    chk("ra_holds_last", {28'b0, ram_ra}, 1);
    check_cnt();

    // Backpressure on a 6-word burst.
    max_out = 0;
    o_ready = 1'b1;
    send(3, 6);
    for (int k = 1; k < 200 && busy; k++) begin
      o_ready = rp[k % 16];
      tick;
    end
    o_ready = 1'b1;
    exp_bursts++;
    wait_idle(50);
    chk("bp_max_outstanding", max_out, 2);
    check_cnt();

    // Request while busy is ignored.
    send(1, 3);
    req_addr = 4'd7; req_len = 5'd2; req_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      chk("busy_req_ready", {31'b0, req_ready}, 0);
      tick;
    end
    req_valid = 1'b0;
    exp_bursts++;
    wait_idle(50);
    repeat (4) tick;
    check_cnt();

    // Reset mid-burst after two words.
    hs_count = 0;
    send(0, 8);
    for (int k = 0; k < 50 && hs_count < 2; k++) tick;
    chk("mid_hs_reached", {31'b0, (hs_count >= 2)}, 1);
    flushing = 1'b1;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    aq.delete();
    dq.delete();
    issued = popped;
    flushing = 1'b0;
    chk("mrst_o_valid", {31'b0, o_valid}, 0);
    chk("mrst_busy", {31'b0, busy}, 0);
    chk("mrst_req_ready", {31'b0, req_ready}, 1);
    exp_bursts = 0;
    check_cnt();
    repeat (5) tick;
    run_basic();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
